// File: rtl/countdown_pkg.sv
// Shared types and helpers for the mm:ss countdown timer: FSM state encoding,
// BCD digit type and the preset clamp.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [3:0] digit_t;

    localparam digit_t BCD_MAX_UNIT = 4'd9;

    // Saturate an out-of-range preset digit to the largest legal value.
    function automatic digit_t clamp_digit(input digit_t d, input digit_t max_val);
        return (d > max_val) ? max_val : d;
    endfunction

endpackage

// File: rtl/bcd_down_mod60.sv
// Two-digit BCD down counter (MAX_TENS9 .. 00) with synchronous load.
// borrow_out fires when a decrement is requested at 00, i.e. on wrap.
module bcd_down_mod60
    import countdown_pkg::*;
#(
    parameter int MAX_TENS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_units,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       is_zero,
    output logic       borrow_out
);

    localparam digit_t TENS_TOP = digit_t'(MAX_TENS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens  <= '0;
            units <= '0;
        end else if (load) begin
            tens  <= load_tens;
            units <= load_units;
        end else if (en) begin
            if (units != 4'd0) begin
                units <= units - 4'd1;
            end else begin
                units <= BCD_MAX_UNIT;
                tens  <= (tens != 4'd0) ? tens - 4'd1 : TENS_TOP;
            end
        end
    end

    assign is_zero    = (tens == 4'd0) && (units == 4'd0);
    assign borrow_out = en && is_zero;

endmodule

// File: rtl/countdown_mmss.sv
// BCD mm:ss countdown timer with done pulse and timed alarm.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic reload from the last preset.
module countdown_mmss
    import countdown_pkg::*;
#(
    parameter int ALARM_TICKS = 3,
    parameter int MAX_TENS    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] set_m1,
    input  logic [3:0] set_m0,
    input  logic [3:0] set_s1,
    input  logic [3:0] set_s0,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [3:0] out_m1,
    output logic [3:0] out_m0,
    output logic [3:0] out_s1,
    output logic [3:0] out_s0,
    output logic       running,
    output logic       done_pulse,
    output logic       alarm
);

    localparam digit_t TENS_MAX   = digit_t'(MAX_TENS);
    localparam logic [3:0] ALARM_INIT = 4'(ALARM_TICKS);

    state_t     state_reg, state_next;
    logic [3:0] alarm_cnt_reg;
    logic       alarm_reg, done_pulse_reg, running_reg;
    logic       sec_zero, min_zero, sec_borrow, min_borrow;
    logic       count_zero, count_one;
    logic       load_acc, start_acc, dec, expiring;
    logic       cnt_load, reload_now, auto_reload;
    logic [15:0] preset_clamped, shadow_digits, ld_digits;

    assign preset_clamped = {clamp_digit(set_m1, TENS_MAX), clamp_digit(set_m0, BCD_MAX_UNIT),
                             clamp_digit(set_s1, TENS_MAX), clamp_digit(set_s0, BCD_MAX_UNIT)};

    assign count_zero = min_zero && sec_zero;
    assign count_one  = min_zero && (out_s1 == 4'd0) && (out_s0 == 4'd1);
    assign load_acc   = load && !clear && (state_reg != ST_RUN);
    assign start_acc  = start && !clear && !load_acc && !count_zero &&
                        ((state_reg == ST_IDLE) || (state_reg == ST_PAUSE));
    assign dec        = tick && !clear && !pause && (state_reg == ST_RUN);
    assign expiring   = dec && count_one;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [15:0] shadow_reg;
    logic        reload_pending_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg         <= '0;
            reload_pending_reg <= 1'b0;
        end else begin
            if (load_acc)
                shadow_reg <= preset_clamped;
            reload_pending_reg <= expiring && auto_reload;
        end
    end

    assign auto_reload   = (shadow_reg != 16'd0);
    assign reload_now    = reload_pending_reg && !clear;
    assign shadow_digits = shadow_reg;
`else
    assign auto_reload   = 1'b0;
    assign reload_now    = 1'b0;
    assign shadow_digits = '0;
`endif

    // A minutes borrow only happens when decrementing from 00:00; reload zeros to hold.
    always_comb begin
        cnt_load  = 1'b1;
        ld_digits = '0;
        if (clear)
            ld_digits = '0;
        else if (load_acc)
            ld_digits = preset_clamped;
        else if (reload_now)
            ld_digits = shadow_digits;
        else if (!min_borrow)
            cnt_load = 1'b0;
    end

    bcd_down_mod60 #(.MAX_TENS(MAX_TENS)) u_sec (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (dec),
        .load       (cnt_load),
        .load_tens  (ld_digits[7:4]),
        .load_units (ld_digits[3:0]),
        .tens       (out_s1),
        .units      (out_s0),
        .is_zero    (sec_zero),
        .borrow_out (sec_borrow)
    );

    bcd_down_mod60 #(.MAX_TENS(MAX_TENS)) u_min (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (sec_borrow),
        .load       (cnt_load),
        .load_tens  (ld_digits[15:12]),
        .load_units (ld_digits[11:8]),
        .tens       (out_m1),
        .units      (out_m0),
        .is_zero    (min_zero),
        .borrow_out (min_borrow)
    );

    always_comb begin
        state_next = state_reg;
        if (clear)
            state_next = ST_IDLE;
        else if (load_acc)
            state_next = ST_IDLE;
        else if (start_acc)
            state_next = ST_RUN;
        else if (pause && (state_reg == ST_RUN))
            state_next = ST_PAUSE;
        else if (expiring)
            state_next = auto_reload ? ST_RUN : ST_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            running_reg    <= 1'b0;
            done_pulse_reg <= 1'b0;
            alarm_reg      <= 1'b0;
            alarm_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            running_reg    <= (state_next == ST_RUN);
            done_pulse_reg <= expiring;
            if (clear || load_acc) begin
                alarm_reg     <= 1'b0;
                alarm_cnt_reg <= '0;
            end else if (expiring) begin
                alarm_reg     <= 1'b1;
                alarm_cnt_reg <= ALARM_INIT;
            end else if (alarm_reg) begin
                // Alarm falls one cycle after the counter has run out.
                if (alarm_cnt_reg == 4'd0)
                    alarm_reg <= 1'b0;
                else if (tick)
                    alarm_cnt_reg <= alarm_cnt_reg - 4'd1;
            end
        end
    end

    assign running    = running_reg;
    assign done_pulse = done_pulse_reg;
    assign alarm      = alarm_reg;

endmodule

// File: tb/tb_countdown_mmss.sv
// Scoreboard bench for countdown_mmss; expected {mm:ss, running, done, alarm}
// words are queued as stimulus is driven and popped after each clock edge.
module tb_countdown_mmss;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [3:0] set_m1 = '0, set_m0 = '0, set_s1 = '0, set_s0 = '0;
    logic [3:0] out_m1, out_m0, out_s1, out_s0;
    logic       running, done_pulse, alarm;

    int          checks = 0;
    int          passed = 0;
    logic [18:0] exp_q[$];
    logic [18:0] e;

    always #5 clk = ~clk;

    countdown_mmss #(.ALARM_TICKS(3), .MAX_TENS(5)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .load(load),
        .set_m1(set_m1), .set_m0(set_m0), .set_s1(set_s1), .set_s0(set_s0),
        .start(start), .pause(pause), .clear(clear),
        .out_m1(out_m1), .out_m0(out_m0), .out_s1(out_s1), .out_s0(out_s0),
        .running(running), .done_pulse(done_pulse), .alarm(alarm)
    );

    function automatic logic [18:0] mk(input logic [3:0] m1, m0, s1, s0, input logic r, d, a);
        return {m1, m0, s1, s0, r, d, a};
    endfunction

    function automatic logic [18:0] obs();
        return {out_m1, out_m0, out_s1, out_s0, running, done_pulse, alarm};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] m1, m0, s1, s0);
        set_m1 = m1; set_m0 = m0; set_s1 = s1; set_s0 = s0;
        load = 1'b1; cyc(); load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1; cyc(); tick = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; cyc(); clear = 1'b0;
    endtask

    task automatic test_reset();
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); repeat (2) cyc();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL reset_held got=%h exp=%h", obs(), e); else passed++;
        rst_n = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); do_tick();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL reset_released got=%h exp=%h", obs(), e); else passed++;
    endtask

    task automatic test_one_minute();
        do_clear();
        exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0)); do_load(0, 1, 0, 0);
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL load_0100 got=%h exp=%h", obs(), e); else passed++;
        exp_q.push_back(mk(0, 1, 0, 0, 1, 0, 0)); do_start();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL start_0100 got=%h exp=%h", obs(), e); else passed++;
        exp_q.push_back(mk(0, 0, 5, 9, 1, 0, 0)); do_tick();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL tick_0059 got=%h exp=%h", obs(), e); else passed++;
    endtask

    task automatic test_expiry();
        do_clear();
        do_load(0, 0, 0, 2);
        do_start();
        exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 0)); do_tick();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL tick_0001 got=%h exp=%h", obs(), e); else passed++;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1)); do_tick();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL expire got=%h exp=%h", obs(), e); else passed++;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1)); cyc();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL pulse_one_cycle got=%h exp=%h", obs(), e); else passed++;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1)); do_tick();
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) $display("FAIL alarm_tick%0d got=%h exp=%h", i, obs(), e); else passed++;
        end
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); cyc();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL alarm_off got=%h exp=%h", obs(), e); else passed++;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); do_start();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL start_in_done got=%h exp=%h", obs(), e); else passed++;
        exp_q.push_back(mk(0, 0, 0, 7, 0, 0, 0)); do_load(0, 0, 0, 7);
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL load_from_done got=%h exp=%h", obs(), e); else passed++;
    endtask

    task automatic test_pause();
        do_clear();
        do_load(1, 2, 3, 4);
        exp_q.push_back(mk(1, 2, 3, 4, 1, 0, 0)); do_start();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL start_1234 got=%h exp=%h", obs(), e); else passed++;
        pause = 1'b1; tick = 1'b1;
        exp_q.push_back(mk(1, 2, 3, 4, 0, 0, 0)); cyc();
        pause = 1'b0; tick = 1'b0;
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL pause_with_tick got=%h exp=%h", obs(), e); else passed++;
        exp_q.push_back(mk(1, 2, 3, 4, 0, 0, 0)); do_tick();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL tick_in_pause got=%h exp=%h", obs(), e); else passed++;
        do_start();
        exp_q.push_back(mk(1, 2, 3, 3, 1, 0, 0)); do_tick();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL resume_tick got=%h exp=%h", obs(), e); else passed++;
    endtask

    task automatic test_clamp_borrow();
        do_clear();
        exp_q.push_back(mk(5, 9, 5, 4, 0, 0, 0)); do_load(7, 12, 9, 4);
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL clamp_load got=%h exp=%h", obs(), e); else passed++;
        do_start();
        exp_q.push_back(mk(5, 9, 5, 3, 1, 0, 0)); do_tick();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL clamp_tick got=%h exp=%h", obs(), e); else passed++;
        do_clear();
        do_load(1, 0, 0, 0);
        do_start();
        exp_q.push_back(mk(0, 9, 5, 9, 1, 0, 0)); do_tick();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL borrow_1000 got=%h exp=%h", obs(), e); else passed++;
        exp_q.push_back(mk(0, 9, 5, 9, 1, 0, 0)); do_load(0, 0, 0, 5);
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL load_in_run got=%h exp=%h", obs(), e); else passed++;
        pause = 1'b1; cyc(); pause = 1'b0;
        exp_q.push_back(mk(0, 0, 3, 0, 0, 0, 0)); do_load(0, 0, 3, 0);
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL load_in_pause got=%h exp=%h", obs(), e); else passed++;
    endtask

    task automatic test_clear();
        do_clear();
        do_load(0, 5, 0, 0);
        do_start();
        exp_q.push_back(mk(0, 4, 5, 9, 1, 0, 0)); do_tick();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL tick_0459 got=%h exp=%h", obs(), e); else passed++;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); do_clear();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL clear_in_run got=%h exp=%h", obs(), e); else passed++;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); do_start();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL start_at_zero got=%h exp=%h", obs(), e); else passed++;
        do_load(0, 0, 0, 1);
        do_start();
        exp_q.push_back(mk(0, 0, 0, 0, AUTO, 1, 1)); do_tick();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL expire_0001 got=%h exp=%h", obs(), e); else passed++;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); do_clear();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL clear_alarm got=%h exp=%h", obs(), e); else passed++;
        do_load(0, 3, 0, 0);
        do_start();
        rst_n = 1'b0;
        #2;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL async_reset got=%h exp=%h", obs(), e); else passed++;
        rst_n = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); do_tick();
        e = exp_q.pop_front(); checks++;
        if (obs() !== e) $display("FAIL after_reset got=%h exp=%h", obs(), e); else passed++;
    endtask

    task automatic test_auto_reload();
        do_clear();
        do_load(0, 0, 0, 3);
        do_start();
        for (int round = 0; round < 2; round++) begin
            exp_q.push_back(mk(0, 0, 0, 2, 1, 0, round[0])); do_tick();
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) $display("FAIL auto_0002_r%0d got=%h exp=%h", round, obs(), e); else passed++;
            exp_q.push_back(mk(0, 0, 0, 1, 1, 0, round[0])); do_tick();
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) $display("FAIL auto_0001_r%0d got=%h exp=%h", round, obs(), e); else passed++;
            exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 1)); do_tick();
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) $display("FAIL auto_expire_r%0d got=%h exp=%h", round, obs(), e); else passed++;
            exp_q.push_back(mk(0, 0, 0, 3, 1, 0, 1)); cyc();
            e = exp_q.pop_front(); checks++;
            if (obs() !== e) $display("FAIL auto_reload_r%0d got=%h exp=%h", round, obs(), e); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_one_minute();
        if (AUTO) test_auto_reload();
        else      test_expiry();
        test_pause();
        test_clamp_borrow();
        test_clear();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/countdown_mmss.md
Name: countdown_mmss

Overview:
- BCD mm:ss countdown timer: counts down from a loaded preset to 00:00, one step per tick.
- Flags expiry with a one-cycle done pulse and a timed alarm.
- Down-counting, borrow-chained counterpart of the up-counting min/sec carry chain in the timer.
- Sits between the 1 Hz tick generator and the display/alarm logic.

Parameters:
- ALARM_TICKS, 3: number of ticks alarm stays high after expiry (1..15).
- MAX_TENS, 5: largest legal tens digit for minutes and seconds.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle strobe, nominally 1 Hz
- load  in  1  load preset digits
- set_m1  in  4  preset minutes tens (BCD)
- set_m0  in  4  preset minutes units (BCD)
- set_s1  in  4  preset seconds tens (BCD)
- set_s0  in  4  preset seconds units (BCD)
- start  in  1  start or resume
- pause  in  1  pause
- clear  in  1  abort; go to 00:00 IDLE
- out_m1  out  4  minutes tens
- out_m0  out  4  minutes units
- out_s1  out  4  seconds tens
- out_s0  out  4  seconds units
- running  out  1  high in RUN
- done_pulse  out  1  one-cycle pulse on reaching 00:00
- alarm  out  1  high for ALARM_TICKS ticks after expiry

Behaviour:
- Reset: clk and rst_n as decided — reset rst_n, asynchronous, active-low; clock clk.
- Reset values: all digits 0, running=0, done_pulse=0, alarm=0, state IDLE, alarm counter 0.
- States:
  - IDLE: count static.
  - RUN: decrement on tick.
  - PAUSE: count frozen.
  - DONE: 00:00 reached, alarm timing.
- Per-cycle input priority: clear > load > start > pause > tick.
- clear, any state: next cycle digits 00:00, IDLE, alarm=0, done_pulse=0.
- load:
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - Digits latched next cycle; state becomes IDLE; alarm cleared.
  - Clamping: units >9 become 9; tens >MAX_TENS become MAX_TENS.
- start:
  - IDLE or PAUSE with count ≠ 00:00 → RUN.
  - Count == 00:00 → state unchanged.
  - Ignored in RUN and DONE.
- pause: RUN → PAUSE. Simultaneous pause and tick in RUN → PAUSE, no decrement.
- Decrement, tick in RUN; result registered and visible the cycle after tick:
  - s0>0: s0 decrements.
  - Else s0=9; then s1>0: s1 decrements.
  - Else s1=MAX_TENS and minutes borrow (same rule for m0/m1).
- Expiry: a tick at 00:01 gives 00:00 next cycle, plus:
  - done_pulse=1 for exactly that cycle.
  - state DONE; alarm=1; alarm counter loaded with ALARM_TICKS.
- DONE:
  - Each tick decrements the alarm counter; alarm drops in the cycle after the counter reaches 0.
  - Count holds 00:00.
  - Leaves DONE only via load or clear.
- running = (state==RUN), registered along with state.
- Ticks in IDLE, PAUSE, or in RUN while at 00:00 (unreachable) cause no change.
- Reset mid-RUN: immediate return to reset values; no done_pulse.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - A shadow register holds the last clamped preset from load.
  - On expiry, done_pulse and alarm behave as above, but the count reloads from the shadow the cycle after reaching 00:00 and the state stays RUN (periodic timer).
  - A shadow of 00:00 never auto-reloads; the state goes to DONE as in the base behaviour.
- Undefined: no shadow register; expiry enters DONE as described.

Decomposition:
- Package countdown_pkg:
  - State enum (IDLE, RUN, PAUSE, DONE), 2-bit encoding.
  - BCD_MAX_UNIT=9 and a 4-bit digit typedef.
  - The clamp function.
- Sub-module bcd_down_mod60:
  - Ports: en, load, load digits; outputs: tens/units, is_zero, borrow_out.
  - Instantiated twice: seconds, and minutes with en = seconds borrow.
- Top holds the FSM, alarm counter and optional shadow register.

Test Plan:
- Load 01:00, start, one tick → 00:59 next cycle, running=1, no done_pulse.
- Load 00:02, start, two ticks → 00:01 then 00:00; done_pulse high 1 cycle; alarm high for exactly 3 further ticks; state DONE.
- Load 12:34, start, pause with tick in the same cycle → stays 12:34, running=0; start then tick → 12:33.
- Load with set_m1=7, set_m0=12, set_s1=9, set_s0=4 → 59:54; start, tick → 59:53.
- RUN at 05:00, clear during the alarm and mid-RUN → 00:00, IDLE, alarm=0. Start at 00:00 → stays IDLE.
- With COUNTDOWN_AUTO_RELOAD_EN, load 00:03, start, 3 ticks → done_pulse, then 00:03 and running=1; 3 more ticks → second done_pulse.
